// File: rtl/psum_seq_pkg.sv
// psum_seq_pkg: op, cache-mode and FSM-state enums shared by the psum cache sequencer
package psum_seq_pkg;
  typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_ACCUM = 2'b01, OP_LOAD = 2'b10, OP_DRAIN = 2'b11} op_e;
  typedef enum logic [1:0] {MODE_HOLD = 2'b00, MODE_ACC = 2'b01, MODE_LOAD = 2'b10, MODE_OUT = 2'b11} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACC, S_LD_ENTER, S_LD, S_DR_ENTER, S_DR, S_FIN} state_e;
endpackage

// File: rtl/psum_seq_beat_counter.sv
// psum_seq_beat_counter: beat counter with clear, increment and terminal-count compare
//   clk, rst (async active-low); clr has priority over inc; tc = (cnt == last)
module psum_seq_beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign tc = (cnt_q == last);
endmodule

// File: rtl/psum_cache_sequencer.sv
// psum_cache_sequencer: command-driven sequencer for one partial-sum cache
//   cmd_*      : clear/accum/load/drain command port (valid/ready)
//   acc_in_*   : accumulate stream, ld_* : load stream, drain_ready : drain flow control
//   cache_*    : cache control and data outputs, cache_idx : cache index for checking
//   busy/done/done_op/idx_err : status
//   Optional PSUM_SEQ_BYPASS_EN: in IDLE, acc_in passes through the cache unaccumulated.
module psum_cache_sequencer
  import psum_seq_pkg::*;
#(
  parameter int BATCH_SIZE = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int I_WIDTH    = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [LEN_WIDTH-1:0]          cmd_len,
  input  logic                          acc_in_valid,
  output logic                          acc_in_ready,
  input  logic [I_WIDTH-1:0]            acc_in,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [PSUM_WIDTH-1:0]         ld_data,
  input  logic                          drain_ready,
  output logic [1:0]                    cache_mode_select,
  output logic                          cache_psum_enable,
  output logic                          cache_psum_clear,
  output logic [PSUM_WIDTH-1:0]         cache_psum_load_in,
  output logic                          cache_in_valid,
  output logic [I_WIDTH-1:0]            cache_in,
  input  logic [$clog2(BATCH_SIZE)-1:0] cache_idx,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    done_op,
  output logic                          idx_err
);
  localparam int IW = $clog2(BATCH_SIZE);
  localparam int CW = LEN_WIDTH > IW ? LEN_WIDTH : IW;
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic idx_err_q, idx_err_d;
  logic beat, clr_cnt, tc, counting;
  logic [CW-1:0] cnt, last;
  psum_seq_beat_counter #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .inc(beat), .last(last), .cnt(cnt), .tc(tc)
  );
  always_comb begin
    counting = (state_q == S_ACC) | (state_q == S_LD) | (state_q == S_DR);
    beat = (state_q == S_ACC & acc_in_valid) | (state_q == S_LD & ld_valid) | (state_q == S_DR & drain_ready);
    last = state_q == S_ACC ? CW'(len_q) - CW'(1) : CW'(BATCH_SIZE - 1);
    clr_cnt = !counting | (beat & tc);
    state_d = state_q;
    op_d = op_q;
    len_d = len_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d = op_e'(cmd_op);
        len_d = cmd_len;
        state_d = op_e'(cmd_op) == OP_CLEAR ? S_CLR :
                  op_e'(cmd_op) == OP_ACCUM ? (cmd_len == '0 ? S_FIN : S_ACC) :
                  op_e'(cmd_op) == OP_LOAD  ? S_LD_ENTER : S_DR_ENTER;
      end
      S_CLR: state_d = S_FIN;
      S_ACC, S_LD, S_DR: if (beat & tc) state_d = S_FIN;
      S_LD_ENTER: state_d = S_LD;
      S_DR_ENTER: state_d = S_DR;
      default: state_d = S_IDLE;
    endcase
    // every load/drain beat must land on the cache entry matching the beat count
    idx_err_d = state_q == S_CLR ? 1'b0 :
                idx_err_q | ((state_q == S_LD | state_q == S_DR) & beat & (CW'(cache_idx) != cnt));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      op_q <= OP_CLEAR;
      len_q <= '0;
      idx_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      len_q <= len_d;
      idx_err_q <= idx_err_d;
    end
  always_comb begin
    cmd_ready = state_q == S_IDLE;
    busy = !cmd_ready;
    acc_in_ready = state_q == S_ACC;
    cache_in_valid = acc_in_ready & acc_in_valid;
    cache_in = acc_in_ready ? acc_in : '0;
    ld_ready = state_q == S_LD;
    cache_psum_load_in = (ld_ready & ld_valid) ? ld_data : '0;
    cache_psum_clear = state_q == S_CLR;
    cache_psum_enable = 1'b1;
    done = state_q == S_FIN;
    done_op = done ? op_q : OP_CLEAR;
    idx_err = idx_err_q;
    // stalled load/drain cycles drop to HOLD so the cache index does not advance
    cache_mode_select = state_q == S_ACC ? MODE_ACC :
                        (state_q == S_LD_ENTER | (ld_ready & ld_valid)) ? MODE_LOAD :
                        (state_q == S_DR_ENTER | (state_q == S_DR & drain_ready)) ? MODE_OUT : MODE_HOLD;
`ifdef PSUM_SEQ_BYPASS_EN
    if (state_q == S_IDLE) begin
      cache_psum_enable = 1'b0;
      acc_in_ready = 1'b1;
      cache_in_valid = acc_in_valid;
      cache_in = acc_in;
    end
`endif
  end
endmodule

// File: tb/tb_psum_cache_sequencer.sv
// tb_psum_cache_sequencer: scoreboard bench for psum_cache_sequencer
module tb_psum_cache_sequencer;
  localparam int B = 16, PW = 32, IWD = 32, LW = 16, XW = $clog2(B);
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [LW-1:0] cmd_len = 0;
  logic acc_in_valid = 0, acc_in_ready;
  logic [IWD-1:0] acc_in = 0;
  logic ld_valid = 0, ld_ready;
  logic [PW-1:0] ld_data = 0;
  logic drain_ready = 0;
  logic [1:0] cache_mode_select;
  logic cache_psum_enable, cache_psum_clear, cache_in_valid;
  logic [PW-1:0] cache_psum_load_in;
  logic [IWD-1:0] cache_in;
  logic [XW-1:0] cache_idx = 0;
  logic busy, done, idx_err;
  logic [1:0] done_op;

  psum_cache_sequencer #(.BATCH_SIZE(B), .PSUM_WIDTH(PW), .I_WIDTH(IWD), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .acc_in_valid(acc_in_valid), .acc_in_ready(acc_in_ready), .acc_in(acc_in),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .drain_ready(drain_ready),
    .cache_mode_select(cache_mode_select), .cache_psum_enable(cache_psum_enable),
    .cache_psum_clear(cache_psum_clear), .cache_psum_load_in(cache_psum_load_in),
    .cache_in_valid(cache_in_valid), .cache_in(cache_in), .cache_idx(cache_idx), .busy(busy),
    .done(done), .done_op(done_op), .idx_err(idx_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [1:0] op; int t;} done_t;
  done_t exp_done[$];
  logic [31:0] exp_acc[$], exp_ld[$];
  int exp_clr[$];
  int exp_mode = -1;
  bit err_model = 0;
  int n_cmp = 0, n_bad = 0;
  done_t m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event absent or unexpected at cycle %0d", name, cyc);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0); chk("rst_cmd_ready", cmd_ready, 1); chk("rst_done", done, 0);
    chk("rst_done_op", done_op, 0); chk("rst_idx_err", idx_err, 0); chk("rst_mode", cache_mode_select, 0);
    chk("rst_clear", cache_psum_clear, 0); chk("rst_ld_ready", ld_ready, 0);
    chk("rst_load_in", cache_psum_load_in, 0);
`ifdef PSUM_SEQ_BYPASS_EN
    chk("rst_enable", cache_psum_enable, 0);
`else
    chk("rst_enable", cache_psum_enable, 1); chk("rst_acc_ready", acc_in_ready, 0);
    chk("rst_in_valid", cache_in_valid, 0); chk("rst_cache_in", cache_in, 0);
`endif
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) if (rst) begin
    if (done) begin
      if (exp_done.size() == 0) miss("done_unexpected");
      else begin
        m = exp_done.pop_front();
        chk("done_op", done_op, m.op);
        chk("done_cycle", cyc, m.t);
      end
    end
    if (cache_psum_clear) begin
      if (exp_clr.size() == 0) miss("clear_unexpected");
      else chk("clear_cycle", cyc, exp_clr.pop_front());
    end
    if (cache_in_valid && busy) begin
      if (exp_acc.size() == 0) miss("acc_beat_unexpected");
      else chk("acc_data", cache_in, exp_acc.pop_front());
    end
    if (ld_ready && ld_valid) begin
      if (exp_ld.size() == 0) miss("ld_beat_unexpected");
      else chk("ld_data", cache_psum_load_in, exp_ld.pop_front());
    end
    if (exp_mode >= 0) chk("mode", cache_mode_select, exp_mode[1:0]);
    if (!busy) begin
      chk("idle_cmd_ready", cmd_ready, 1); chk("idle_ld_ready", ld_ready, 0);
      chk("idle_clear", cache_psum_clear, 0); chk("idle_mode", cache_mode_select, 0);
`ifdef PSUM_SEQ_BYPASS_EN
      chk("idle_acc_ready", acc_in_ready, 1); chk("idle_enable", cache_psum_enable, 0);
`else
      chk("idle_acc_ready", acc_in_ready, 0); chk("idle_in_valid", cache_in_valid, 0);
      chk("idle_enable", cache_psum_enable, 1);
`endif
    end
  end

  // kind: 0 random gaps, 1 stall every 3rd cycle, 2 toggling, 3 fixed 1,0,1,1,0,1,1
  task automatic issue(input logic [1:0] op, input int len, input int kind, input int bad_at, input int rst_at);
    int pat[$];
    int gap[7] = '{1, 0, 1, 1, 0, 1, 1};
    int ones = 0, need, i = 0, k = 0, t0, beats = 0, v;
    done_t e;
    need = op == 2'b01 ? len : op[1] ? B : 0;
    while (ones < need) begin
      v = kind == 1 ? int'(i % 3 != 2) : kind == 2 ? i % 2 : kind == 3 ? (i < 7 ? gap[i] : 1) :
          int'($urandom_range(0, 3) != 0);
      pat.push_back(v);
      ones += v;
      i++;
    end
    while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!cmd_ready) begin miss("cmd_ready_timeout"); return; end
    t0 = cyc;
    cmd_valid = 1; cmd_op = op; cmd_len = LW'(len);
    if (op == 2'b00) begin exp_clr.push_back(t0 + 1); err_model = 0; end
    e.op = op;
    e.t = op == 2'b00 ? t0 + 2 : op == 2'b01 ? t0 + 1 + pat.size() : t0 + 2 + pat.size();
    exp_done.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_len = LW'($urandom);
    if (op[1]) begin
      exp_mode = op == 2'b10 ? 2 : 3;
      ld_valid = 1; ld_data = $urandom; drain_ready = 1;
      @(posedge clk); #1;
    end
    foreach (pat[j]) begin
      if (beats == rst_at) begin
        drain_ready = 1; cache_idx = XW'(beats);
        #2 rst = 0;
        #1 chk_reset_vals();
        exp_done.delete(); exp_acc.delete(); exp_ld.delete(); exp_clr.delete();
        exp_mode = -1; err_model = 0; drain_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        return;
      end
      exp_mode = op == 2'b01 ? 1 : pat[j] != 0 ? (op == 2'b10 ? 2 : 3) : 0;
      cache_idx = XW'(beats) ^ XW'(beats == bad_at && pat[j] != 0);
      if (op == 2'b01) begin
        acc_in_valid = pat[j][0]; acc_in = $urandom;
        if (pat[j] != 0) exp_acc.push_back(acc_in);
      end else if (op == 2'b10) begin
        ld_valid = pat[j][0]; ld_data = $urandom;
        if (pat[j] != 0) exp_ld.push_back(ld_data);
      end else drain_ready = pat[j][0];
      if (beats == bad_at && pat[j] != 0) err_model = 1;
      beats += pat[j];
      @(posedge clk); #1;
    end
    exp_mode = -1;
    acc_in_valid = 1'($urandom); ld_valid = 1'($urandom); drain_ready = 1'($urandom);
    acc_in = $urandom; ld_data = $urandom;
    k = 0;
    while (exp_done.size() != 0 && k < 40) begin @(posedge clk); #1; k++; end
    if (exp_done.size() != 0) begin miss("done_timeout"); exp_done.delete(); end
    if (exp_acc.size() != 0 || exp_ld.size() != 0) begin miss("beats_left_over"); exp_acc.delete(); exp_ld.delete(); end
    chk("idx_err", idx_err, err_model);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    rst = 1;
    issue(2'b00, 0, 0, -1, -1);
    issue(2'b01, 5, 3, -1, -1);
    issue(2'b01, 0, 0, -1, -1);
    issue(2'b10, 0, 1, -1, -1);
    issue(2'b11, 0, 2, -1, -1);
    issue(2'b10, 0, 0, 5, -1);
    issue(2'b01, 3, 0, -1, -1);
    issue(2'b11, 0, 0, -1, -1);
    issue(2'b00, 0, 0, -1, -1);
    for (int r = 0; r < 24; r++)
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 0, -1, -1);
    issue(2'b11, 0, 2, -1, 7);
    issue(2'b10, 0, 0, -1, -1);
    issue(2'b01, 4, 0, -1, -1);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
